addr_port_arbiter: RTL and testbench

ADDR_PORT_ARBITER -- requirements
Module: addr_port_arbiter

---
 rtl/addr_port_arbiter_if.sv | 40 ++++
 rtl/addr_port_arbiter.sv | 86 ++++++++
 tb/tb_addr_port_arbiter.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/addr_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : addr_port_arbiter_if
// Description : Bus bundle for the two-requester address port arbiter.
//               Requesters present payloads with req*_in/datain*; the
//               arbiter returns one-cycle grant strobes and offers the held
//               payload downstream with a valid/ready handshake.
//   req1_in/datain1, req2_in/datain2 : requester payloads
//   gnt1_out/gnt2_out                : capture strobes (combinational)
//   select_out/data_out/valid_out    : registered held payload
//   ready_in                         : downstream accept
// Revision    : 1.0 - initial release
// ============================================================================
interface addr_port_arbiter_if #(
  parameter int WORD_SIZE = 5
);
  logic                 req1_in;
  logic [WORD_SIZE-1:0] datain1;
  logic                 req2_in;
  logic [WORD_SIZE-1:0] datain2;
  logic                 gnt1_out;
  logic                 gnt2_out;
  logic                 select_out;
  logic [WORD_SIZE-1:0] data_out;
  logic                 valid_out;
  logic                 ready_in;

  // Environment side: requesters plus downstream consumer.
  modport master (
    output req1_in, datain1, req2_in, datain2, ready_in,
    input  gnt1_out, gnt2_out, select_out, data_out, valid_out
  );

  // Arbiter side.
  modport slave (
    input  req1_in, datain1, req2_in, datain2, ready_in,
    output gnt1_out, gnt2_out, select_out, data_out, valid_out
  );
endinterface
`default_nettype wire

// File: rtl/addr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : addr_port_arbiter
// Description : Round-robin arbiter between two register-file address
//               requesters feeding a single-entry output holding register.
//               A payload is captured whenever the holding register is empty
//               or being drained this cycle, giving zero-bubble
//               back-to-back transfers.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : addr_port_arbiter_if.slave (requests, grants, held payload)
// Revision    : 1.0 - initial release
// ============================================================================
module addr_port_arbiter #(
  parameter int WORD_SIZE = 5
) (
  input  wire                  clk,
  input  wire                  rst,
  addr_port_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [WORD_SIZE-1:0] r_data;
  logic [WORD_SIZE-1:0] w_data_nxt;
  logic                 r_sel;
  logic                 w_sel_nxt;
  // 1 = requester 2 was served by the most recent load.
  logic                 r_last2;
  logic                 w_last2_nxt;

  logic                 w_any_req;
  logic                 w_load;
  logic                 w_win2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_data  <= '0;
      r_sel   <= 1'b0;
      r_last2 <= 1'b1;   // requester 1 wins the first tie
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data_nxt;
      r_sel   <= w_sel_nxt;
      r_last2 <= w_last2_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_data_nxt  = r_data;
    w_sel_nxt   = r_sel;
    w_last2_nxt = r_last2;

    w_any_req = bus.req1_in | bus.req2_in;
    // The slot is free when empty, or when its current payload leaves now.
    // Grants are suppressed while reset is held so nothing is consumed.
    w_load    = ((r_state == S_IDLE) | bus.ready_in) & w_any_req & ~rst;
    // Requester 2 wins if alone, or on a tie when requester 1 went last.
    w_win2    = bus.req2_in & (~bus.req1_in | ~r_last2);

    if (w_load) begin
      w_state_nxt = S_HOLD;
      w_data_nxt  = w_win2 ? bus.datain2 : bus.datain1;
      w_sel_nxt   = w_win2;
      w_last2_nxt = w_win2;
    end else if ((r_state == S_HOLD) && bus.ready_in) begin
      // Drained with nothing waiting; payload and select are kept.
      w_state_nxt = S_IDLE;
    end
  end

  assign bus.gnt1_out   = w_load & ~w_win2;
  assign bus.gnt2_out   = w_load &  w_win2;
  assign bus.valid_out  = (r_state == S_HOLD);
  assign bus.data_out   = r_data;
  assign bus.select_out = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_addr_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_addr_port_arbiter
// Description : Self-checking bench for addr_port_arbiter: directed vector
//               table, hand-written corner sequences, and randomized
//               traffic against a transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_addr_port_arbiter;

  localparam int W = 5;

  logic clk;
  logic rst;

  addr_port_arbiter_if #(.WORD_SIZE(W)) bus ();

  addr_port_arbiter #(.WORD_SIZE(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: slot contents plus which requester was served last.
  int m_valid;
  int m_sel;
  int m_data;
  int m_last;   // 1 or 2

  // Observed and model-predicted values of the latest cycle.
  logic [1:0] act_g;   // {gnt1, gnt2}
  logic [6:0] act_o;   // {valid, select, data}
  logic [1:0] mod_g;
  logic [6:0] mod_o;

  typedef struct {
    logic       r1;
    logic [W-1:0] d1;
    logic       r2;
    logic [W-1:0] d2;
    logic       rdy;
    logic [1:0] g;
    logic [6:0] o;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(logic r1, logic [W-1:0] d1, logic r2,
                              logic [W-1:0] d2, logic rdy, logic [1:0] g,
                              logic v, logic s, logic [W-1:0] d);
    vec_t x;
    x.r1 = r1; x.d1 = d1; x.r2 = r2; x.d2 = d2; x.rdy = rdy;
    x.g = g; x.o = {v, s, d};
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_sel = 0; m_data = 0; m_last = 2;
  endtask

  // One clock: drive at the falling edge, sample grants before the rising
  // edge, sample registered outputs shortly after it.
  task automatic cycle(input logic r1, input logic [W-1:0] d1,
                       input logic r2, input logic [W-1:0] d2,
                       input logic rdy);
    int win;
    @(negedge clk);
    bus.req1_in = r1; bus.datain1 = d1;
    bus.req2_in = r2; bus.datain2 = d2;
    bus.ready_in = rdy;
    #1;
    act_g = {bus.gnt1_out, bus.gnt2_out};

    win = 0;
    if (m_valid == 0 || rdy) begin
      if (r1 && r2)  win = (m_last == 1) ? 2 : 1;
      else if (r1)   win = 1;
      else if (r2)   win = 2;
    end
    mod_g = {win == 1, win == 2};

    @(posedge clk);
    if (win != 0) begin
      m_valid = 1;
      m_data  = (win == 1) ? int'(d1) : int'(d2);
      m_sel   = (win == 2) ? 1 : 0;
      m_last  = win;
    end else if (m_valid != 0 && rdy) begin
      m_valid = 0;
    end
    #1;
    act_o = {bus.valid_out, bus.select_out, bus.data_out};
    mod_o = {m_valid[0], m_sel[0], m_data[W-1:0]};
  endtask

  // Assert reset mid-cycle with a request pending; outputs must clear at once.
  task automatic do_reset(input string tag);
    @(negedge clk);
    bus.req1_in = 1'b1; bus.req2_in = 1'b1; bus.ready_in = 1'b1;
    rst = 1'b1;
    #1;
    chk({tag, "_rst_out"}, {25'd0, bus.valid_out, bus.select_out,
                            bus.data_out}, 32'd0);
    chk({tag, "_rst_gnt"}, {30'd0, bus.gnt1_out, bus.gnt2_out}, 32'd0);
    model_reset();
    @(negedge clk);
    bus.req1_in = 1'b0; bus.req2_in = 1'b0; bus.ready_in = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.req1_in = 1'b0; bus.datain1 = '0;
    bus.req2_in = 1'b0; bus.datain2 = '0;
    bus.ready_in = 1'b0;
    model_reset();

    //            r1 d1     r2 d2     rdy gnt    v  s  data
    vt[0]  = mk(1, 5'h0A, 0, 5'h00, 0, 2'b10, 1, 0, 5'h0A);
    vt[1]  = mk(0, 5'h00, 0, 5'h00, 0, 2'b00, 1, 0, 5'h0A);
    vt[2]  = mk(0, 5'h00, 0, 5'h00, 0, 2'b00, 1, 0, 5'h0A);
    vt[3]  = mk(0, 5'h00, 0, 5'h00, 1, 2'b00, 0, 0, 5'h0A);
    vt[4]  = mk(0, 5'h00, 0, 5'h00, 0, 2'b00, 0, 0, 5'h0A);
    vt[5]  = mk(0, 5'h00, 0, 5'h00, 1, 2'b00, 0, 0, 5'h0A);
    vt[6]  = mk(1, 5'h03, 1, 5'h1C, 1, 2'b01, 1, 1, 5'h1C);
    vt[7]  = mk(1, 5'h03, 1, 5'h1C, 1, 2'b10, 1, 0, 5'h03);
    vt[8]  = mk(1, 5'h03, 1, 5'h1C, 1, 2'b01, 1, 1, 5'h1C);
    vt[9]  = mk(1, 5'h03, 1, 5'h1C, 0, 2'b00, 1, 1, 5'h1C);
    vt[10] = mk(0, 5'h00, 1, 5'h07, 1, 2'b01, 1, 1, 5'h07);
    vt[11] = mk(1, 5'h15, 0, 5'h00, 1, 2'b10, 1, 0, 5'h15);
    vt[12] = mk(0, 5'h00, 0, 5'h00, 1, 2'b00, 0, 0, 5'h15);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_state", {25'd0, bus.valid_out, bus.select_out, bus.data_out},
        32'd0);
    chk("reset_gnt", {30'd0, bus.gnt1_out, bus.gnt2_out}, 32'd0);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < 13; i++) begin
      cycle(vt[i].r1, vt[i].d1, vt[i].r2, vt[i].d2, vt[i].rdy);
      chk($sformatf("vec%0d_gnt", i), {30'd0, act_g}, {30'd0, vt[i].g});
      chk($sformatf("vec%0d_out", i), {25'd0, act_o}, {25'd0, vt[i].o});
    end

    // Both requesting from reset with ready high: strict alternation.
    do_reset("alt");
    for (int i = 0; i < 4; i++) begin
      cycle(1, 5'h03, 1, 5'h1C, 1);
      chk($sformatf("alt%0d_gnt", i), {30'd0, act_g},
          (i % 2 == 0) ? 32'b10 : 32'b01);
      chk($sformatf("alt%0d_out", i), {25'd0, act_o},
          (i % 2 == 0) ? {25'd0, 1'b1, 1'b0, 5'h03}
                       : {25'd0, 1'b1, 1'b1, 5'h1C});
    end

    // Held payload, requester 2 waits for three stalled cycles.
    cycle(1, 5'h11, 0, 5'h00, 1);
    chk("stall_load", {25'd0, act_o}, {25'd0, 1'b1, 1'b0, 5'h11});
    for (int i = 0; i < 3; i++) begin
      cycle(0, 5'h00, 1, 5'h07, 0);
      chk($sformatf("stall%0d_gnt", i), {30'd0, act_g}, 32'd0);
      chk($sformatf("stall%0d_out", i), {25'd0, act_o},
          {25'd0, 1'b1, 1'b0, 5'h11});
    end
    cycle(0, 5'h00, 1, 5'h07, 1);
    chk("stall_rel_gnt", {30'd0, act_g}, 32'b01);
    chk("stall_rel_out", {25'd0, act_o}, {25'd0, 1'b1, 1'b1, 5'h07});

    // Reset while holding, then the first tie goes to requester 1.
    do_reset("midhold");
    cycle(1, 5'h03, 1, 5'h1C, 0);
    chk("post_rst_tie_gnt", {30'd0, act_g}, 32'b10);
    chk("post_rst_tie_out", {25'd0, act_o}, {25'd0, 1'b1, 1'b0, 5'h03});

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), W'($urandom),
            1'($urandom_range(0, 1)), W'($urandom),
            1'($urandom_range(0, 3) != 0));
      chk($sformatf("rnd%0d_gnt", i), {30'd0, act_g}, {30'd0, mod_g});
      chk($sformatf("rnd%0d_out", i), {25'd0, act_o}, {25'd0, mod_o});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
